// File: rtl/hs_npu_mem_streamer.sv
// Streams INT8/INT16 rows from a beat-oriented memory read port into lane-unpacked rows.
// Each row is sign-extended to ELEM_W per lane. Up to MAX_OUTSTANDING reads can be in flight.
module hs_npu_mem_streamer #(
    parameter int SIZE            = 8,
    parameter int ELEM_W          = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [31:0]              cfg_base_addr,
    input  logic [15:0]              cfg_rows,
    input  logic                     cfg_elem16,
    input  logic [1:0]               cfg_dest,
    input  logic                     abort,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [31:0]              mem_req_addr,
    input  logic                     mem_rsp_valid,
    output logic                     mem_rsp_ready,
    input  logic [32*(SIZE/4)-1:0]   mem_rsp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE*ELEM_W-1:0]   out_data,
    output logic [1:0]               out_dest,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int LINE_WORDS = SIZE / 4;
    localparam int HALF       = SIZE / 2;
    localparam int ROW_W      = SIZE * ELEM_W;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] BEAT_BYTES = 32'(4 * LINE_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_FLUSH} state_t;

    state_t                  r_state;
    logic [31:0]             r_req_addr;
    logic [15:0]             r_rows;
    logic [15:0]             r_row_cnt;
    logic                    r_elem16;
    logic [1:0]              r_dest;
    logic [16:0]             r_total;
    logic [16:0]             r_req_cnt;
    logic [OUT_W-1:0]        r_outstanding;
    logic                    r_half_valid;
    logic [HALF*ELEM_W-1:0]  r_half;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_done;
    logic [ROW_W-1:0]        r_out_data;

    logic                    w_req_hs;
    logic                    w_rsp_hs;
    logic                    w_out_hs;
    logic                    w_cfg_hs;
    logic                    w_dec;
    logic [OUT_W-1:0]        w_outstanding_nxt;
    logic [ROW_W-1:0]        w_row8;
    logic [HALF*ELEM_W-1:0]  w_beat16;

    assign cfg_ready     = (r_state == ST_IDLE) && !rst;
    assign mem_req_valid = (r_state == ST_STREAM) && (r_req_cnt < r_total) &&
                           (r_outstanding < OUT_W'(MAX_OUTSTANDING));
    assign mem_req_addr  = r_req_addr;
    assign mem_rsp_ready = (r_state == ST_STREAM) ? (!r_out_valid || out_ready)
                                                  : (r_state == ST_FLUSH);
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_dest      = r_dest;
    assign out_last      = r_out_last;
    assign busy          = (r_state != ST_IDLE);
    assign done          = r_done;

    assign w_req_hs = mem_req_valid && mem_req_ready;
    assign w_rsp_hs = mem_rsp_valid && mem_rsp_ready;
    assign w_out_hs = r_out_valid && out_ready;
    assign w_cfg_hs = cfg_valid && cfg_ready;
    // A response with nothing outstanding is a protocol error; never underflow.
    assign w_dec    = w_rsp_hs && (r_outstanding != '0);

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_req_hs && !w_dec)
            w_outstanding_nxt = r_outstanding + OUT_W'(1);
        else if (!w_req_hs && w_dec)
            w_outstanding_nxt = r_outstanding - OUT_W'(1);
    end

    always_comb begin
        w_row8   = '0;
        w_beat16 = '0;
        for (int unsigned k = 0; k < SIZE; k++)
            w_row8[k*ELEM_W +: ELEM_W] = ELEM_W'($signed(mem_rsp_data[8*k +: 8]));
        for (int unsigned j = 0; j < HALF; j++)
            w_beat16[j*ELEM_W +: ELEM_W] = ELEM_W'($signed(mem_rsp_data[16*j +: 16]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req_addr    <= '0;
            r_rows        <= '0;
            r_row_cnt     <= '0;
            r_elem16      <= 1'b0;
            r_dest        <= '0;
            r_total       <= '0;
            r_req_cnt     <= '0;
            r_outstanding <= '0;
            r_half_valid  <= 1'b0;
            r_half        <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_data    <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_outstanding_nxt;
            if (w_out_hs)
                r_out_valid <= 1'b0;
            if (w_req_hs) begin
                r_req_addr <= r_req_addr + BEAT_BYTES;
                r_req_cnt  <= r_req_cnt + 17'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_hs) begin
                        r_req_addr   <= cfg_base_addr;
                        r_rows       <= cfg_rows;
                        r_elem16     <= cfg_elem16;
                        r_dest       <= cfg_dest;
                        r_total      <= cfg_elem16 ? {cfg_rows, 1'b0} : {1'b0, cfg_rows};
                        r_req_cnt    <= '0;
                        r_row_cnt    <= '0;
                        r_half_valid <= 1'b0;
                        if (cfg_rows == '0)
                            r_done  <= 1'b1;
                        else
                            r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_out_valid  <= 1'b0;
                        r_half_valid <= 1'b0;
                        r_state      <= (w_outstanding_nxt == '0) ? ST_IDLE : ST_FLUSH;
                    end else begin
                        if (w_out_hs && r_out_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                        if (w_rsp_hs) begin
                            if (r_elem16 && !r_half_valid) begin
                                r_half       <= w_beat16;
                                r_half_valid <= 1'b1;
                            end else begin
                                r_half_valid <= 1'b0;
                                r_out_valid  <= 1'b1;
                                r_out_data   <= r_elem16 ? {w_beat16, r_half} : w_row8;
                                r_out_last   <= (r_row_cnt == r_rows - 16'd1);
                                r_row_cnt    <= r_row_cnt + 16'd1;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_outstanding_nxt == '0)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_npu_mem_streamer.sv
// Scoreboard bench for hs_npu_mem_streamer: memory model, row/address queues, directed jobs.
module tb_hs_npu_mem_streamer;
    localparam int SIZE = 8;
    localparam int ELEM_W = 16;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_valid = 1'b0, cfg_ready, cfg_elem16 = 1'b0, abort = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [15:0] cfg_rows = '0;
    logic [1:0]  cfg_dest = '0;
    logic mem_req_valid, mem_req_ready = 1'b1, mem_rsp_valid = 1'b0, mem_rsp_ready;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_rsp_data = '0;
    logic out_valid, out_ready = 1'b1, out_last, busy, done;
    logic [127:0] out_data;
    logic [1:0]  out_dest;

    typedef struct { logic [127:0] data; logic last; logic [1:0] dest; } exp_t;
    exp_t        sb[$];
    logic [31:0] exp_addr[$];
    logic [31:0] pend[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    hs_npu_mem_streamer #(.SIZE(SIZE), .ELEM_W(ELEM_W), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base_addr(cfg_base_addr),
        .cfg_rows(cfg_rows), .cfg_elem16(cfg_elem16), .cfg_dest(cfg_dest), .abort(abort),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    function automatic logic [63:0] beat_of(input logic [31:0] a);
        case (a)
            32'h0000_1000: return {32'h7F800102, 32'h80FF017F};
            32'h0000_2000: return {32'h1234FEDC, 32'h80007FFF};
            32'h0000_2008: return {32'hFFFF0001, 32'h00008001};
            default:       return {mix(a + 32'd4), mix(a)};
        endcase
    endfunction

    function automatic logic [127:0] row_i8(input logic [63:0] b);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = {{8{b[8*k+7]}}, b[8*k +: 8]};
        return r;
    endfunction

    // Zero-latency memory: a request accepted at one edge is answered in the following cycle.
    always begin
        @(negedge clk);
        mem_rsp_valid = (pend.size() != 0) && !rst;
        mem_rsp_data  = mem_rsp_valid ? beat_of(pend[0]) : '0;
        #1;
        if (rst) pend.delete();
        else begin
            if (mem_rsp_valid && mem_rsp_ready) void'(pend.pop_front());
            if (mem_req_valid && mem_req_ready) begin
                chk("req_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) chk("req_addr", mem_req_addr, exp_addr.pop_front());
                pend.push_back(mem_req_addr);
                chk("outstanding_le_max", pend.size() <= MAXO, 1);
            end
        end
    end

    // Output monitor: scoreboard pop, hold stability, done pulse timing.
    logic         exp_done = 1'b0;
    logic         held_valid = 1'b0;
    logic [127:0] held_data = '0;
    exp_t         e_mon;
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_done   = 1'b0;
            held_valid = 1'b0;
        end else begin
            chk("done_pulse", done, exp_done);
            exp_done = 1'b0;
            if (cfg_valid && cfg_ready && cfg_rows == 16'd0) exp_done = 1'b1;
            if (out_valid) begin
                if (held_valid) chk("out_data_stable", out_data, held_data);
                if (out_ready) begin
                    held_valid = 1'b0;
                    chk("row_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e_mon = sb.pop_front();
                        chk("row_data", out_data, e_mon.data);
                        chk("row_last", out_last, e_mon.last);
                        chk("row_dest", out_dest, e_mon.dest);
                        hs_cyc.push_back(cyc);
                        if (e_mon.last) exp_done = 1'b1;
                    end
                end else begin
                    held_valid = 1'b1;
                    held_data  = out_data;
                end
            end else held_valid = 1'b0;
        end
    end

    task automatic start_job(input logic [31:0] base, input logic [15:0] rows,
                             input logic e16, input logic [1:0] dest);
        int beats = e16 ? 2 * int'(rows) : int'(rows);
        for (int n = 0; n < beats; n++) exp_addr.push_back(base + 32'(8 * n));
        for (int r = 0; r < int'(rows); r++) begin
            exp_t e;
            logic [31:0] a0;
            a0 = base + 32'(8 * (e16 ? 2 * r : r));
            e.data = e16 ? {beat_of(a0 + 32'd8), beat_of(a0)} : row_i8(beat_of(a0));
            e.last = (r == int'(rows) - 1);
            e.dest = dest;
            sb.push_back(e);
        end
        cfg_base_addr = base;
        cfg_rows      = rows;
        cfg_elem16    = e16;
        cfg_dest      = dest;
        cfg_valid     = 1'b1;
        #1;
        chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((busy || sb.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("job_within_budget", c < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_ready_after_rst", cfg_ready, 1);

        // INT8 job with literal first row; one row per cycle with out_ready high.
        hs_cyc.delete();
        start_job(32'h1000, 16'd3, 1'b0, 2'd2);
        sb[0].data = 128'h007F_FF80_0001_0002_FF80_FFFF_0001_007F;
        chk("busy_stream", busy, 1);
        chk("cfg_ready_busy", cfg_ready, 0);
        wait_idle(50);
        chk("rows_a", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) chk("throughput", hs_cyc[2] - hs_cyc[0], 2);

        // New job accepted during the done pulse; INT16 rows.
        chk("done_at_cfg", done, 1);
        start_job(32'h2000, 16'd2, 1'b1, 2'd1);
        sb[0].data = 128'hFFFF_0001_0000_8001_1234_FEDC_8000_7FFF;
        wait_idle(60);

        // Backpressure for 10 cycles, then random out_ready.
        out_ready = 1'b0;
        start_job(32'h3000, 16'd8, 1'b0, 2'd3);
        repeat (10) @(negedge clk);
        chk("bp_outstanding", pend.size(), 2);
        chk("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_idle(100);

        // Abort with two reads in flight.
        out_ready = 1'b0;
        start_job(32'h4000, 16'd8, 1'b0, 2'd0);
        repeat (6) @(negedge clk);
        chk("abort_pre_outstanding", pend.size(), 2);
        chk("abort_pre_valid", out_valid, 1);
        sb.delete();
        exp_addr.delete();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_flush_busy", busy, 1);
        chk("abort_no_req", mem_req_valid, 0);
        chk("abort_rsp_ready", mem_rsp_ready, 1);
        wait_idle(20);
        chk("abort_drained", pend.size(), 0);
        out_ready = 1'b1;
        start_job(32'h5000, 16'd1, 1'b0, 2'd1);
        wait_idle(30);

        // Zero-row job: done next cycle, no requests.
        @(negedge clk);
        start_job(32'h7000, 16'd0, 1'b0, 2'd0);
        chk("rows0_done", done, 1);
        chk("rows0_busy", busy, 0);
        @(negedge clk);
        chk("rows0_no_req", mem_req_valid, 0);
        chk("rows0_done_clear", done, 0);

        // Address wrap.
        start_job(32'hFFFF_FFF8, 16'd2, 1'b0, 2'd2);
        wait_idle(30);

        // Reset mid-stream.
        out_ready = 1'b0;
        start_job(32'h6000, 16'd8, 1'b0, 2'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        exp_addr.delete();
        @(negedge clk);
        chk("mid_rst_cfg_ready", cfg_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_out_dest", out_dest, 0);
        chk("mid_rst_req_valid", mem_req_valid, 0);
        chk("mid_rst_req_addr", mem_req_addr, 0);
        chk("mid_rst_rsp_ready", mem_rsp_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start_job(32'h6100, 16'd2, 1'b1, 2'd3);
        wait_idle(60);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hs_npu_mem_streamer.md
HS_NPU_MEM_STREAMER -- requirements
Module: hs_npu_mem_streamer

Interface
REQ-001 SHALL have parameter SIZE, default 8, lanes per row (multiple of 4).
REQ-002 SHALL have parameter ELEM_W, default 16, output lane width (>=16).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight read requests (>=1).
REQ-004 SHALL derive LINE_WORDS = SIZE/4 (32-bit words per memory beat).
REQ-005 Ports, in order:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_valid/cfg_ready  in/out  1  job handshake.
- cfg_base_addr  in  32  byte address of row 0.
- cfg_rows  in  16  row count.
- cfg_elem16  in  1  0 = INT8 rows, 1 = INT16 rows.
- cfg_dest  in  2  destination tag, echoed on out_dest.
- abort  in  1  cancel the current job.
- mem_req_valid/mem_req_ready  out/in  1  read-request handshake.
- mem_req_addr  out  32  beat byte address.
- mem_rsp_valid/mem_rsp_ready  in/out  1  read-response handshake.
- mem_rsp_data  in  32*LINE_WORDS  beat data; word w is at bits [32w+31:32w].
- out_valid/out_ready  out/in  1  row-stream handshake.
- out_data  out  SIZE*ELEM_W  row; lane k is at bits [k*ELEM_W +: ELEM_W].
- out_dest  out  2  latched cfg_dest.
- out_last  out  1  asserted with the final row.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement the states IDLE, STREAM and FLUSH.
REQ-007 cfg_ready SHALL be 1 only in IDLE.
REQ-008 On a cfg handshake, SHALL latch all cfg_* fields and compute total_beats = cfg_rows*(cfg_elem16 ? 2 : 1).
- If cfg_rows != 0, SHALL enter STREAM.
- If cfg_rows == 0, SHALL stay in IDLE, pulse done on the next cycle, and issue no request.
REQ-009 In STREAM, mem_req_valid SHALL be 1 iff requested < total_beats and outstanding < MAX_OUTSTANDING.
REQ-010 Request n (0-based) SHALL carry address base + 4*LINE_WORDS*n, modulo 2^32.
REQ-011 outstanding SHALL increment on a request handshake and decrement on a response handshake; on simultaneous events it SHALL stay unchanged.
REQ-012 In STREAM, mem_rsp_ready SHALL equal (!out_valid || out_ready).
REQ-013 INT8 unpacking: lane k SHALL be byte (k%4) of word (k/4), sign-extended to ELEM_W; one beat SHALL produce one row.
REQ-014 INT16 unpacking: two beats SHALL form one row.
- Beat 0 fills lanes 0..SIZE/2-1; beat 1 fills lanes SIZE/2..SIZE-1.
- Lane j within a beat SHALL be halfword (j%2) of word (j/2), sign-extended.
- Beat 0 SHALL be held in an internal half-row register that produces no output.
REQ-015 A row-completing response handshake SHALL load the out register and set out_valid on the next cycle (latency 1).
REQ-016 out_valid SHALL hold, with out_data stable, until out_ready.
REQ-017 Back-to-back responses SHALL sustain one row per cycle while out_ready=1 (INT8 mode).
REQ-018 out_last SHALL be 1 with the row whose index equals cfg_rows-1, and 0 otherwise.
REQ-019 The out handshake of the last row SHALL return the block to IDLE and pulse done for exactly the next cycle.
REQ-020 A new cfg handshake SHALL be accepted in the same cycle that done pulses.
REQ-021 abort in STREAM SHALL:
- clear out_valid and the half-row register, and stop requests, the next cycle;
- enter FLUSH.
REQ-022 In FLUSH:
- mem_rsp_ready SHALL be 1 and responses SHALL be discarded;
- when outstanding == 0, the block SHALL go to IDLE with no done pulse.
- If outstanding is already 0 at abort, the block SHALL go directly to IDLE.
REQ-023 abort in IDLE or FLUSH SHALL be ignored.
REQ-024 A response arriving with outstanding == 0 is a protocol violation; the block SHALL not decrement below 0.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL enter IDLE and clear the following to 0: counters, outstanding, half-row register, out_valid, out_data, out_last, out_dest, mem_req_valid, mem_req_addr, mem_rsp_ready, done, busy.
REQ-026 cfg_ready SHALL be 0 while rst=1 and 1 from the first cycle after release.
REQ-027 Reset mid-job SHALL abandon the job without a done pulse; in-flight responses after reset are the memory system's responsibility.

Verification
REQ-028 INT8 job, SIZE=8, base=0x1000, rows=3, zero-latency memory, out_ready=1:
- expected: requests to 0x1000, 0x1008, 0x1010;
- beat word 0x80FF017F gives lanes 0x007F, 0x0001, 0xFFFF, 0xFF80;
- out_last on row 2; done one cycle after the row-2 handshake.
REQ-029 INT16 job, rows=2:
- expected: 4 requests and 2 rows;
- beat-0 word 0x8000_7FFF gives lane0=0x7FFF, lane1=0x8000; lanes 4..7 come from beat 1.
REQ-030 Backpressure: MAX_OUTSTANDING=2, out_ready=0 for 10 cycles:
- outstanding never exceeds 2;
- out_data stays stable;
- no row is lost or duplicated across 8 rows.
REQ-031 Abort with 2 outstanding:
- out_valid drops the next cycle;
- the 2 late responses are accepted and discarded;
- IDLE is reached with no done pulse;
- the next job (rows=1) completes correctly.
REQ-032 Boundaries:
- rows=0 gives done the next cycle and no mem_req_valid;
- base=0xFFFFFFF8, rows=2, INT8 gives addresses 0xFFFFFFF8 and 0x00000000;
- rst asserted mid-STREAM gives all outputs at reset values the next cycle.
